// File: rtl/bus_cycle_ctrl.sv
// Registered 68000 bus-cycle terminator: DTACK after per-device wait states, BERR/forced DTACK on timeout.
// Optional: define BUS_CYCLE_BERR_EN to signal unmapped accesses with BERR instead of a silent DTACK.
module bus_cycle_ctrl #(
  parameter int unsigned SRAM_WAIT = 0,
  parameter int unsigned PROM_WAIT = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic CPUCLK_IN,
  input  logic RESET_IN,
  input  logic AS,
  input  logic UDS,
  input  logic LDS,
  input  logic SRAMCS0,
  input  logic SRAMCS1,
  input  logic PROMCS0,
  input  logic PROMCS1,
  output logic DTACK,
  output logic BERR,
  output logic ACTIVE
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    T_NONE,
    T_SRAM,
    T_PROM
  } target_t;

  state_t        state, state_n;
  target_t       tgt, tgt_n, tgt_dec;
  logic [CW-1:0] count, count_n;
  logic [1:0]    as_sync, uds_sync, lds_sync, sync_ok;
  logic          sas, suds, slds;
  logic          dtack_q, dtack_n, active_q, active_n;
  logic          sram_sel, prom_sel;
  logic          berr_n;

  assign sas  = as_sync[1];
  assign suds = uds_sync[1];
  assign slds = lds_sync[1];

  assign sram_sel = ~SRAMCS0 | ~SRAMCS1;
  assign prom_sel = ~PROMCS0 | ~PROMCS1;

  always_comb begin
    tgt_dec = T_NONE;
    if (sram_sel && !prom_sel)
      tgt_dec = T_SRAM;
    else if (prom_sel && !sram_sel)
      tgt_dec = T_PROM;
  end

  // sync_ok marks when the synchroniser holds real AS samples rather than its reset value
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      as_sync  <= '1;
      uds_sync <= '1;
      lds_sync <= '1;
      sync_ok  <= '0;
      state    <= S_ARM;
      tgt      <= T_NONE;
      count    <= '0;
      dtack_q  <= 1'b1;
      active_q <= 1'b0;
    end else begin
      as_sync  <= {as_sync[0], AS};
      uds_sync <= {uds_sync[0], UDS};
      lds_sync <= {lds_sync[0], LDS};
      sync_ok  <= {sync_ok[0], 1'b1};
      state    <= state_n;
      tgt      <= tgt_n;
      count    <= count_n;
      dtack_q  <= dtack_n;
      active_q <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    tgt_n    = tgt;
    count_n  = count;
    dtack_n  = dtack_q;
    active_n = active_q;
    berr_n   = 1'b1;
    case (state)
      S_ARM: begin
        if (sync_ok[1] && sas)
          state_n = S_IDLE;
      end
      S_IDLE: begin
        if (!sas && (!suds || !slds)) begin
          tgt_n    = tgt_dec;
          count_n  = '0;
          active_n = 1'b1;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sas) begin
          active_n = 1'b0;
          state_n  = S_IDLE;
        end else begin
          if (count != '1)
            count_n = count + 1'b1;
          case (tgt)
            T_SRAM: begin
              if (count == CW'(SRAM_WAIT)) begin
                dtack_n = 1'b0;
                state_n = S_ACK;
              end
            end
            T_PROM: begin
              if (count == CW'(PROM_WAIT)) begin
                dtack_n = 1'b0;
                state_n = S_ACK;
              end
            end
            default: begin
              if (count == CW'(TIMEOUT - 1)) begin
`ifdef BUS_CYCLE_BERR_EN
                berr_n  = 1'b0;
`else
                dtack_n = 1'b0;
`endif
                state_n = S_FAULT;
              end
            end
          endcase
        end
      end
      S_ACK: begin
        if (sas) begin
          dtack_n  = 1'b1;
          active_n = 1'b0;
          state_n  = S_IDLE;
        end
      end
      S_FAULT: begin
        if (sas) begin
          dtack_n  = 1'b1;
          active_n = 1'b0;
          state_n  = S_IDLE;
        end else begin
`ifdef BUS_CYCLE_BERR_EN
          berr_n = 1'b0;
`endif
        end
      end
      default: state_n = S_ARM;
    endcase
  end

`ifdef BUS_CYCLE_BERR_EN
  logic berr_q;

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN)
      berr_q <= 1'b1;
    else
      berr_q <= berr_n;
  end

  assign BERR = berr_q;
`else
  assign BERR = 1'b1;

  logic unused_berr;
  assign unused_berr = berr_n;
`endif

  assign DTACK  = dtack_q;
  assign ACTIVE = active_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: per-cycle reference model plus directed literal checks.
module tb_bus_cycle_ctrl;

  localparam int unsigned P_SRAM = 0;
  localparam int unsigned P_PROM = 2;
  localparam int unsigned P_TO   = 64;

  logic CPUCLK_IN = 1'b0;
  logic RESET_IN, AS, UDS, LDS, SRAMCS0, SRAMCS1, PROMCS0, PROMCS1;
  logic DTACK, BERR, ACTIVE;

  int checks = 0;
  int passes = 0;

  bus_cycle_ctrl #(
    .SRAM_WAIT(P_SRAM),
    .PROM_WAIT(P_PROM),
    .TIMEOUT  (P_TO)
  ) dut (
    .CPUCLK_IN(CPUCLK_IN),
    .RESET_IN (RESET_IN),
    .AS       (AS),
    .UDS      (UDS),
    .LDS      (LDS),
    .SRAMCS0  (SRAMCS0),
    .SRAMCS1  (SRAMCS1),
    .PROMCS0  (PROMCS0),
    .PROMCS1  (PROMCS1),
    .DTACK    (DTACK),
    .BERR     (BERR),
    .ACTIVE   (ACTIVE)
  );

  always #5 CPUCLK_IN = ~CPUCLK_IN;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: a strobe seen two edges late; a cycle terminates a fixed
  // number of edges after its start, and ends when the late-seen AS is high.
  bit m_valid = 0;
  bit m_dtack = 1, m_berr = 1, m_active = 0;
  bit m_ready, m_busy, m_unmapped;
  bit d1_as, d2_as, d1_uds, d2_uds, d1_lds, d2_lds, f1, f2;
  int m_n, m_lat;

  always @(posedge CPUCLK_IN) begin
    bit s_as, s_uds, s_lds, s_ok;
    int nsram, nprom;
    if (RESET_IN) begin
      m_valid = 1;
      {d1_as, d2_as, d1_uds, d2_uds, d1_lds, d2_lds} = '1;
      {f1, f2} = '0;
      m_ready = 0; m_busy = 0;
      m_dtack = 1; m_berr = 1; m_active = 0;
    end else if (m_valid) begin
      s_as = d2_as; s_uds = d2_uds; s_lds = d2_lds; s_ok = f2;
      d2_as = d1_as; d1_as = AS;
      d2_uds = d1_uds; d1_uds = UDS;
      d2_lds = d1_lds; d1_lds = LDS;
      f2 = f1; f1 = 1;
      if (!m_ready) begin
        if (s_ok && s_as) m_ready = 1;
      end else if (!m_busy) begin
        if (!s_as && (!s_uds || !s_lds)) begin
          nsram = int'(!SRAMCS0) + int'(!SRAMCS1);
          nprom = int'(!PROMCS0) + int'(!PROMCS1);
          m_unmapped = 0;
          if (nsram > 0 && nprom == 0) m_lat = P_SRAM;
          else if (nprom > 0 && nsram == 0) m_lat = P_PROM;
          else begin m_lat = P_TO - 1; m_unmapped = 1; end
          m_busy = 1; m_n = 0; m_active = 1;
        end
      end else begin
        m_n++;
        if (s_as) begin
          m_busy = 0; m_dtack = 1; m_berr = 1; m_active = 0;
        end else if (m_n == m_lat + 1) begin
`ifdef BUS_CYCLE_BERR_EN
          if (m_unmapped) m_berr = 0;
          else m_dtack = 0;
`else
          m_dtack = 0;
`endif
        end
      end
    end
  end

  always @(negedge CPUCLK_IN) begin
    if (m_valid) begin
      chk("model_dtack", DTACK, m_dtack);
      chk("model_berr", BERR, m_berr);
      chk("model_active", ACTIVE, m_active);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CPUCLK_IN);
    #1;
  endtask

  task automatic idle_bus();
    AS = 1; UDS = 1; LDS = 1;
    SRAMCS0 = 1; SRAMCS1 = 1; PROMCS0 = 1; PROMCS1 = 1;
  endtask

  task automatic chk_unmapped_term(input string name);
`ifdef BUS_CYCLE_BERR_EN
    chk({name, "_berr"}, BERR, 1'b0);
    chk({name, "_dtack"}, DTACK, 1'b1);
`else
    chk({name, "_dtack"}, DTACK, 1'b0);
    chk({name, "_berr"}, BERR, 1'b1);
`endif
  endtask

  initial begin
    idle_bus();
    RESET_IN = 1; AS = 0; LDS = 0; SRAMCS0 = 0;
    edges(3);
    chk("reset_dtack", DTACK, 1'b1);
    chk("reset_berr", BERR, 1'b1);
    chk("reset_active", ACTIVE, 1'b0);
    RESET_IN = 0;
    edges(8);
    chk("arm_no_start_active", ACTIVE, 1'b0);
    chk("arm_no_start_dtack", DTACK, 1'b1);
    idle_bus();
    edges(4);

    // SRAM, zero wait
    SRAMCS0 = 0; LDS = 0; AS = 0;
    edges(3);
    chk("sram_e3_dtack", DTACK, 1'b1);
    edges(1);
    chk("sram_e4_dtack", DTACK, 1'b0);
    chk("sram_e4_active", ACTIVE, 1'b1);
    edges(2);
    idle_bus();
    edges(3);
    chk("sram_release_dtack", DTACK, 1'b1);
    chk("sram_release_active", ACTIVE, 1'b0);
    edges(2);

    // PROM, two waits
    PROMCS1 = 0; UDS = 0; AS = 0;
    edges(5);
    chk("prom_e5_dtack", DTACK, 1'b1);
    edges(1);
    chk("prom_e6_dtack", DTACK, 1'b0);
    edges(10);
    chk("prom_hold_dtack", DTACK, 1'b0);
    idle_bus();
    edges(3);
    chk("prom_release_dtack", DTACK, 1'b1);
    edges(2);

    // unmapped
    LDS = 0; AS = 0;
    edges(66);
    chk("none_e66_dtack", DTACK, 1'b1);
    chk("none_e66_berr", BERR, 1'b1);
    chk("none_e66_active", ACTIVE, 1'b1);
    edges(1);
    chk_unmapped_term("none_e67");
    edges(5);
    chk_unmapped_term("none_hold");
    idle_bus();
    edges(3);
    chk("none_release_dtack", DTACK, 1'b1);
    chk("none_release_berr", BERR, 1'b1);
    chk("none_release_active", ACTIVE, 1'b0);
    edges(2);

    // decode error: SRAM and PROM together
    SRAMCS0 = 0; PROMCS0 = 0; LDS = 0; AS = 0;
    edges(4);
    chk("decerr_e4_dtack", DTACK, 1'b1);
    edges(63);
    chk_unmapped_term("decerr_e67");
    idle_bus();
    edges(5);

    // aborted PROM cycle: AS rises after edge 2, seen by the FSM at count 1
    PROMCS0 = 0; UDS = 0; AS = 0;
    edges(2);
    AS = 1; UDS = 1;
    edges(1);
    chk("abort_e3_active", ACTIVE, 1'b1);
    edges(2);
    chk("abort_e5_active", ACTIVE, 1'b0);
    chk("abort_e5_dtack", DTACK, 1'b1);
    edges(3);
    chk("abort_e8_dtack", DTACK, 1'b1);
    idle_bus();
    edges(2);
    SRAMCS1 = 0; UDS = 0; AS = 0;
    edges(4);
    chk("post_abort_sram_dtack", DTACK, 1'b0);
    idle_bus();
    edges(5);

    // reset mid-cycle, AS still low afterwards
    SRAMCS0 = 0; LDS = 0; AS = 0;
    edges(4);
    chk("midrst_pre_dtack", DTACK, 1'b0);
    RESET_IN = 1;
    edges(1);
    chk("midrst_dtack", DTACK, 1'b1);
    chk("midrst_active", ACTIVE, 1'b0);
    RESET_IN = 0;
    edges(8);
    chk("midrst_arm_active", ACTIVE, 1'b0);
    AS = 1; LDS = 1;
    edges(5);
    AS = 0; LDS = 0;
    edges(4);
    chk("midrst_recover_dtack", DTACK, 1'b0);
    idle_bus();
    edges(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
